// File: rtl/gm_line_fetch.sv
// Framebuffer line fetcher: reads one row of 32-bit words per line_start over a pipelined
// Wishbone read master and writes each returned word into the pixel FIFO. Define
// GM_LINE_FETCH_BSWAP_EN to byte-swap returned words for little-endian framebuffers.
module gm_line_fetch #(
   parameter int AWIDTH  = 32,
   parameter int WCNT_W  = 8,
   parameter int MAX_OUT = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   // Handshake: a read issues on a cycle with stb=1 and stall=0; the slave returns one ack
   // (with dat_i valid) per issued read, in issue order, any number of cycles later.
   output logic              bus_cyc,
   output logic              bus_stb,
   output logic [AWIDTH-1:0] bus_adr,
   output logic              bus_we,
   output logic [3:0]        bus_sel,
   output logic [31:0]       bus_dat_o,
   input  logic [31:0]       bus_dat_i,
   input  logic              bus_ack,
   input  logic              bus_stall,
   input  logic              frame_start,
   input  logic              line_start,
   input  logic [AWIDTH-1:0] base_adr,
   input  logic [15:0]       stride,
   input  logic [WCNT_W-1:0] words_per_line,
   input  logic [2:0]        line_repeat,
   input  logic              fifo_afull,
   input  logic              fifo_full,
   output logic              fifo_write,
   output logic [31:0]       fifo_data,
   output logic              busy,
   input  logic              clr_err,
   output logic              overrun,
   output logic              drop_err,
   output logic [1:0]        state_dbg
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_BUS      = 2'd1,
      S_ACK_WAIT = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [AWIDTH-1:0] row_adr, line_adr;
   logic [WCNT_W-1:0] idx, wpl_q;
   logic [15:0]       stride_q;
   logic [2:0]        rep_q, rep_cnt;
   logic [3:0]        outstanding, outstanding_nxt;
   logic              skip_adv;
   logic              issue, ack_v, start, last_issue, line_done;

   assign bus_cyc    = (state != S_IDLE);
   assign busy       = bus_cyc;
   assign state_dbg  = state;
   assign bus_stb    = (state == S_BUS) && (outstanding < 4'(MAX_OUT)) && !fifo_afull;
   assign bus_adr    = line_adr + AWIDTH'({idx, 2'b00});
   assign bus_we     = 1'b0;
   assign bus_sel    = 4'hf;
   assign bus_dat_o  = 32'h0;

   // Acks outside a line belong to an abandoned fetch and are discarded.
   assign ack_v      = bus_ack && (state != S_IDLE);
   assign issue      = bus_stb && !bus_stall;
   assign start      = line_start && (state == S_IDLE) && (words_per_line != '0);
   assign last_issue = issue && (idx == wpl_q - WCNT_W'(1));
   assign fifo_write = ack_v && !fifo_full;

`ifdef GM_LINE_FETCH_BSWAP_EN
   assign fifo_data = {bus_dat_i[7:0], bus_dat_i[15:8], bus_dat_i[23:16], bus_dat_i[31:24]};
`else
   assign fifo_data = bus_dat_i;
`endif

   always_comb begin
      outstanding_nxt = outstanding;
      if (issue && !ack_v)
         outstanding_nxt = outstanding + 4'd1;
      else if (!issue && ack_v && (outstanding != 4'd0))
         outstanding_nxt = outstanding - 4'd1;
   end

   assign line_done = (state == S_ACK_WAIT) && (outstanding_nxt == 4'd0);

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     if (start) state_nxt = S_BUS;
         S_BUS:      if (last_issue) state_nxt = S_ACK_WAIT;
         S_ACK_WAIT: if (line_done) state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state       <= S_IDLE;
         outstanding <= 4'd0;
         idx         <= '0;
         wpl_q       <= '0;
         rep_q       <= 3'd0;
         stride_q    <= 16'd0;
         line_adr    <= '0;
      end else begin
         state       <= state_nxt;
         outstanding <= outstanding_nxt;
         if (start) begin
            wpl_q    <= words_per_line;
            rep_q    <= line_repeat;
            stride_q <= stride;
            line_adr <= frame_start ? base_adr : row_adr;
            idx      <= '0;
         end
         if (issue)
            idx <= idx + WCNT_W'(1);
         if (line_done)
            idx <= '0;
      end
   end

   // A frame_start during a line suppresses that line's end-of-line row advance,
   // so the next line begins exactly at the reloaded base.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         row_adr  <= '0;
         rep_cnt  <= 3'd0;
         skip_adv <= 1'b0;
      end else if (frame_start) begin
         row_adr  <= base_adr;
         rep_cnt  <= 3'd0;
         skip_adv <= (state != S_IDLE) && !line_done;
      end else if (line_done) begin
         if (skip_adv) begin
            skip_adv <= 1'b0;
         end else if (rep_cnt == rep_q) begin
            row_adr <= row_adr + AWIDTH'(stride_q);
            rep_cnt <= 3'd0;
         end else begin
            rep_cnt <= rep_cnt + 3'd1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         overrun  <= 1'b0;
         drop_err <= 1'b0;
      end else begin
         if (line_start && (state != S_IDLE))
            overrun <= 1'b1;
         else if (clr_err)
            overrun <= 1'b0;
         if (ack_v && fifo_full)
            drop_err <= 1'b1;
         else if (clr_err)
            drop_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_gm_line_fetch.sv
// Bench for gm_line_fetch: table of line vectors, hand-written corner sequences and
// randomized frames checked against a row/line address model and an in-order data scoreboard.
module tb_gm_line_fetch;
   localparam int AWIDTH  = 32;
   localparam int WCNT_W  = 8;
   localparam int MAX_OUT = 4;

   logic              clk_i;
   logic              rst_i = 1'b0;
   logic              bus_cyc, bus_stb, bus_we;
   logic [AWIDTH-1:0] bus_adr;
   logic [3:0]        bus_sel;
   logic [31:0]       bus_dat_o;
   logic [31:0]       bus_dat_i = 32'h0;
   logic              bus_ack = 1'b0, bus_stall = 1'b0;
   logic              frame_start = 1'b0, line_start = 1'b0, clr_err = 1'b0;
   logic [AWIDTH-1:0] base_adr = '0;
   logic [15:0]       stride = 16'h0;
   logic [WCNT_W-1:0] words_per_line = '0;
   logic [2:0]        line_repeat = 3'd0;
   logic              fifo_afull = 1'b0, fifo_full = 1'b0;
   logic              fifo_write, busy, overrun, drop_err;
   logic [31:0]       fifo_data;
   logic [1:0]        state_dbg;

   gm_line_fetch #(.AWIDTH(AWIDTH), .WCNT_W(WCNT_W), .MAX_OUT(MAX_OUT)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .bus_cyc(bus_cyc), .bus_stb(bus_stb), .bus_adr(bus_adr), .bus_we(bus_we),
      .bus_sel(bus_sel), .bus_dat_o(bus_dat_o), .bus_dat_i(bus_dat_i),
      .bus_ack(bus_ack), .bus_stall(bus_stall),
      .frame_start(frame_start), .line_start(line_start), .base_adr(base_adr),
      .stride(stride), .words_per_line(words_per_line), .line_repeat(line_repeat),
      .fifo_afull(fifo_afull), .fifo_full(fifo_full), .fifo_write(fifo_write),
      .fifo_data(fifo_data), .busy(busy), .clr_err(clr_err), .overrun(overrun),
      .drop_err(drop_err), .state_dbg(state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk_i = 1'b1;
      forever #5 clk_i = ~clk_i;
   end

   // ---------------- scoreboard state ----------------
   typedef struct {
      int          due;
      logic [31:0] dat;
      bit          live;
   } pend_t;

   pend_t             pend_q[$];
   logic [31:0]       exp_q[$];
   logic [AWIDTH-1:0] exp_adr_q[$];
   int n_tests = 0, n_fail = 0;

   int cyc_n = 0, lat = 1, last_due = 0, out_tb = 0, peak = 0;
   int line_issues, first_issue_cyc, last_issue_cyc, last_ack_cyc, busy_fall_cyc, ls_cycle;
   int afull_issues = 0, afull_cycles = 0, cyc_high_cnt = 0, drops = 0, late_acks = 0;
   int stb_at_limit = 0, stb_missing = 0;
   logic [AWIDTH-1:0] first_issue_adr;
   logic [31:0] last_fifo_data = 32'h0, fixed_dat = 32'h0, d_tmp;
   bit stall_en = 0, afull_rand = 0, afull_force = 0, full_force = 0, fixed_en = 0;
   bit ack_live = 0, busy_prev = 0;
   pend_t pe;

   // reference model: row = base + stride * (line_in_frame / (repeat+1))
   logic [31:0] m_base = 32'h0;
   int          m_line = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc_n);
      end
   endtask

   function automatic logic [31:0] exp_word(input logic [31:0] d);
`ifdef GM_LINE_FETCH_BSWAP_EN
      return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
      return d;
`endif
   endfunction

   // ---------------- slave + monitor ----------------
   always begin
      @(negedge clk_i);
      cyc_n++;
      bus_ack   = 1'b0;
      ack_live  = 1'b0;
      bus_dat_i = $urandom();
      if (pend_q.size() > 0 && pend_q[0].due <= cyc_n) begin
         pe        = pend_q.pop_front();
         bus_ack   = 1'b1;
         bus_dat_i = pe.dat;
         ack_live  = pe.live;
      end
      bus_stall  = stall_en && ($urandom_range(0, 3) == 0);
      fifo_afull = afull_force || (afull_rand && $urandom_range(0, 4) == 0);
      fifo_full  = full_force;
      #1;
      if (rst_i) begin
         if (line_start) ls_cycle = cyc_n;
         if (bus_cyc) cyc_high_cnt++;
         if (fifo_afull && busy) afull_cycles++;
         if (bus_stb && out_tb >= MAX_OUT) stb_at_limit++;
         if (state_dbg == 2'd1 && out_tb < MAX_OUT && !fifo_afull && !bus_stb) stb_missing++;
         if (busy_prev && !busy) busy_fall_cyc = cyc_n;
         busy_prev = busy;
         if (bus_cyc && bus_stb && !bus_stall) begin
            line_issues++;
            if (line_issues == 1) begin
               first_issue_cyc = cyc_n;
               first_issue_adr = bus_adr;
            end
            last_issue_cyc = cyc_n;
            if (fifo_afull) afull_issues++;
            if (exp_adr_q.size() == 0) check("unexpected_issue", bus_adr, 64'hdead);
            else check("bus_adr", bus_adr, exp_adr_q.pop_front());
            check("bus_fields", {bus_we, bus_sel, bus_dat_o}, {1'b0, 4'hf, 32'h0});
            d_tmp = fixed_en ? fixed_dat : $urandom();
            last_due = (cyc_n + lat > last_due + 1) ? cyc_n + lat : last_due + 1;
            pend_q.push_back('{due: last_due, dat: d_tmp, live: 1'b1});
            exp_q.push_back(exp_word(d_tmp));
            out_tb++;
            if (out_tb > peak) peak = out_tb;
            check("outstanding_limit", (out_tb <= MAX_OUT), 1);
         end
         if (bus_ack) begin
            if (ack_live) begin
               out_tb--;
               last_ack_cyc = cyc_n;
               if (fifo_full) begin
                  drops++;
                  check("drop_no_write", fifo_write, 0);
                  if (exp_q.size() > 0) exp_q.delete(0);
               end else begin
                  check("fifo_write", fifo_write, 1);
                  if (exp_q.size() > 0) check("fifo_data", fifo_data, exp_q.pop_front());
                  else check("fifo_data_extra", fifo_data, 64'hdead);
                  last_fifo_data = fifo_data;
               end
            end else begin
               late_acks++;
               check("late_ack_ignored", fifo_write, 0);
            end
         end else if (fifo_write) begin
            check("spurious_write", fifo_write, 0);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic pulse_ls();
      @(negedge clk_i) line_start = 1'b1;
      @(negedge clk_i) line_start = 1'b0;
   endtask

   task automatic pulse_clr();
      @(negedge clk_i) clr_err = 1'b1;
      @(negedge clk_i) clr_err = 1'b0;
      #2;
   endtask

   task automatic do_frame(input logic [31:0] b);
      @(negedge clk_i);
      base_adr    = b;
      frame_start = 1'b1;
      @(negedge clk_i) frame_start = 1'b0;
      m_base = b;
      m_line = 0;
   endtask

   task automatic start_line(input int wpl, input int lat_v);
      logic [31:0] row;
      words_per_line  = WCNT_W'(wpl);
      lat             = lat_v;
      line_issues     = 0;
      peak            = 0;
      busy_fall_cyc   = -1;
      last_ack_cyc    = -100;
      first_issue_adr = 32'hffff_ffff;
      if (wpl != 0) begin
         row = m_base + 32'(stride) * 32'(m_line / (int'(line_repeat) + 1));
         for (int i = 0; i < wpl; i++) exp_adr_q.push_back(row + 32'(4 * i));
         m_line++;
      end
      pulse_ls();
   endtask

   task automatic wait_done(input int bound);
      int k = 0;
      while (k < bound && !(busy === 1'b0 && pend_q.size() == 0)) begin
         @(negedge clk_i);
         #2;
         k++;
      end
      check("done_in_time", (k < bound), 1);
      check("all_issued", exp_adr_q.size(), 0);
   endtask

   task automatic run_line(input int wpl, input int lat_v);
      start_line(wpl, lat_v);
      wait_done(3000);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit          frame;
      logic [31:0] base;
      logic [15:0] strd;
      int          wpl;
      logic [2:0]  rep;
      logic [31:0] exp_first;
   } vec_t;

   vec_t vecs[7];

   initial begin
      vecs[0] = '{1'b1, 32'h1000, 16'h0200, 80, 3'd0, 32'h1000};
      vecs[1] = '{1'b0, 32'h1000, 16'h0200, 4,  3'd0, 32'h1200};
      vecs[2] = '{1'b1, 32'h0,    16'd320,  8,  3'd1, 32'd0};
      vecs[3] = '{1'b0, 32'h0,    16'd320,  8,  3'd1, 32'd0};
      vecs[4] = '{1'b0, 32'h0,    16'd320,  8,  3'd1, 32'd320};
      vecs[5] = '{1'b0, 32'h0,    16'd320,  8,  3'd1, 32'd320};
      vecs[6] = '{1'b0, 32'h0,    16'd320,  1,  3'd1, 32'd640};

      // reset values
      repeat (3) @(negedge clk_i);
      #2;
      check("rst_cyc", bus_cyc, 0);
      check("rst_stb", bus_stb, 0);
      check("rst_adr", bus_adr, 0);
      check("rst_fifo_write", fifo_write, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      check("rst_drop_err", drop_err, 0);
      check("rst_state", state_dbg, 0);
      @(negedge clk_i) rst_i = 1'b1;
      repeat (2) @(negedge clk_i);

      // table-driven lines on a zero-wait slave
      for (int v = 0; v < 7; v++) begin
         stride      = vecs[v].strd;
         line_repeat = vecs[v].rep;
         if (vecs[v].frame) do_frame(vecs[v].base);
         run_line(vecs[v].wpl, 1);
         check("vec_first_adr", first_issue_adr, vecs[v].exp_first);
         check("vec_issue_count", line_issues, vecs[v].wpl);
         check("vec_first_latency", first_issue_cyc - ls_cycle, 1);
         check("vec_back_to_back", last_issue_cyc - first_issue_cyc, vecs[v].wpl - 1);
         check("vec_busy_fall", busy_fall_cyc, last_ack_cyc + 1);
      end

      // outstanding limit with a slow slave
      stride = 16'h40; line_repeat = 3'd0;
      do_frame(32'h8000);
      run_line(8, 10);
      check("outstanding_peak", peak, MAX_OUT);
      check("stb_at_limit", stb_at_limit, 0);

      // back-pressure window of 20 cycles
      do_frame(32'h9000);
      start_line(40, 2);
      repeat (5) @(negedge clk_i);
      afull_issues = 0;
      afull_cycles = 0;
      @(posedge clk_i) afull_force = 1;
      repeat (20) @(posedge clk_i);
      afull_force = 0;
      wait_done(3000);
      check("afull_window", afull_cycles, 20);
      check("afull_no_issue", afull_issues, 0);
      check("afull_issue_count", line_issues, 40);
      check("afull_no_drop", drop_err, 0);

      // ack dropped while fifo_full
      drops = 0;
      do_frame(32'h4000);
      start_line(16, 1);
      repeat (5) @(negedge clk_i);
      @(posedge clk_i) full_force = 1;
      repeat (2) @(posedge clk_i);
      full_force = 0;
      wait_done(3000);
      check("drop_seen", (drops > 0), 1);
      check("drop_err_set", drop_err, 1);
      repeat (3) @(negedge clk_i);
      #2;
      check("drop_err_sticky", drop_err, 1);
      pulse_clr();
      check("drop_err_clr", drop_err, 0);

      // line_start while busy
      do_frame(32'h7000);
      start_line(20, 3);
      repeat (3) @(negedge clk_i);
      pulse_ls();
      #2;
      check("overrun_set", overrun, 1);
      wait_done(3000);
      check("overrun_line_count", line_issues, 20);
      start_line(20, 3);
      repeat (2) @(negedge clk_i);
      @(negedge clk_i) begin line_start = 1'b1; clr_err = 1'b1; end
      @(negedge clk_i) begin line_start = 1'b0; clr_err = 1'b0; end
      #2;
      check("overrun_set_wins", overrun, 1);
      wait_done(3000);
      check("overrun_next_row", first_issue_adr, 32'h7040);
      pulse_clr();
      check("overrun_clr", overrun, 0);

      // words_per_line = 0 is ignored
      stride = 16'h100;
      do_frame(32'h5000);
      run_line(4, 1);
      check("wpl0_pre_row", first_issue_adr, 32'h5000);
      cyc_high_cnt = 0;
      start_line(0, 1);
      repeat (10) @(negedge clk_i);
      #2;
      check("wpl0_no_cyc", cyc_high_cnt, 0);
      check("wpl0_not_busy", busy, 0);
      run_line(4, 1);
      check("wpl0_no_advance", first_issue_adr, 32'h5100);

      // frame_start during S_ACK_WAIT
      do_frame(32'h2000);
      start_line(4, 8);
      for (int k = 0; k < 100 && line_issues < 4; k++) begin
         @(negedge clk_i);
         #2;
      end
      @(negedge clk_i);
      base_adr    = 32'h3000;
      frame_start = 1'b1;
      #2;
      check("fs_in_ack_wait", state_dbg, 2);
      @(negedge clk_i) frame_start = 1'b0;
      m_base = 32'h3000;
      m_line = 0;
      wait_done(3000);
      run_line(4, 1);
      check("fs_reload_row", first_issue_adr, 32'h3000);
      run_line(4, 1);
      check("fs_then_advance", first_issue_adr, 32'h3100);

      // byte-swap path on a known word
      fixed_en = 1;
      fixed_dat = 32'h1122_3344;
      run_line(1, 1);
      fixed_en = 0;
`ifdef GM_LINE_FETCH_BSWAP_EN
      check("bswap_word", last_fifo_data, 32'h4433_2211);
`else
      check("bswap_word", last_fifo_data, 32'h1122_3344);
`endif

      // randomized frames with stalls and random back-pressure
      stall_en = 1;
      for (int f = 0; f < 6; f++) begin
         int nl;
         afull_rand  = (f % 2 == 1);
         stride      = 16'($urandom_range(0, 16383) * 4);
         line_repeat = 3'($urandom_range(0, 3));
         do_frame((f == 0) ? 32'hffff_fff0 : ($urandom() & 32'hffff_fffc));
         nl = $urandom_range(3, 6);
         for (int l = 0; l < nl; l++) begin
            int w;
            w = $urandom_range(1, 24);
            run_line(w, $urandom_range(1, 6));
            check("rand_issue_count", line_issues, w);
         end
      end
      stall_en = 0;
      afull_rand = 0;
      check("stb_missing", stb_missing, 0);

      // asynchronous reset mid-line, late acks afterwards
      stride = 16'h80; line_repeat = 3'd0;
      do_frame(32'ha000);
      start_line(20, 5);
      repeat (6) @(negedge clk_i);
      #2;
      rst_i = 1'b0;
      foreach (pend_q[i]) pend_q[i].live = 0;
      exp_q.delete();
      exp_adr_q.delete();
      out_tb = 0;
      late_acks = 0;
      #1;
      check("arst_cyc", bus_cyc, 0);
      check("arst_stb", bus_stb, 0);
      check("arst_busy", busy, 0);
      check("arst_adr", bus_adr, 0);
      check("arst_state", state_dbg, 0);
      @(negedge clk_i);
      #2;
      rst_i = 1'b1;
      busy_prev = 0;
      for (int k = 0; k < 200 && pend_q.size() > 0; k++) begin
         @(negedge clk_i);
         #2;
      end
      check("arst_late_acks_seen", (late_acks > 0), 1);
      m_base = 32'h0;
      m_line = 0;
      run_line(3, 1);
      check("arst_row_zero", first_issue_adr, 32'h0);
      check("arst_flags", {overrun, drop_err}, 2'b00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got 1, expected 0");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/gm_line_fetch.md
# gm_line_fetch

Parametrised framebuffer line fetcher for the VGA graphics modes. On each line-start pulse it reads one row of packed pixel words from memory over a pipelined Wishbone master and pushes each returned word into the write side of the pixel FIFO. It supports a programmable base address and row stride, line repetition for vertical pixel doubling, and a bounded number of outstanding reads. It sits in the CPU/memory clock domain, between the memory arbiter and the dual-clock FIFO that feeds the scan-out and palette stage.

## Interface
- AWIDTH, 32: bus address width.
- WCNT_W, 8: width of the words-per-line count; at most 2^WCNT_W−1 words per line.
- MAX_OUT, 4: maximum bus reads issued but not yet acked; 1..15.
- clk_i  in  1  bus/CPU clock.
- rst_i  in  1  reset, asynchronous, active-low.
- bus  if_wb.master  —  Wishbone read master: cyc, stb, adr, we, sel, dat_o/dat_m, dat_i/dat_s, ack, stall.
- frame_start  in  1  pulse: reload the row pointer from base_adr.
- line_start  in  1  pulse: fetch the current row.
- base_adr  in  AWIDTH  byte address of row 0; must be word-aligned.
- stride  in  16  byte increment between rows; must be word-aligned.
- words_per_line  in  WCNT_W  number of 32-bit words per row.
- line_repeat  in  3  each row is fetched line_repeat+1 times.
- fifo_afull  in  1  FIFO has fewer than MAX_OUT free entries.
- fifo_full  in  1  FIFO full.
- fifo_write  out  1  FIFO write strobe.
- fifo_data  out  32  FIFO write data.
- busy  out  1  a line fetch is in progress.
- clr_err  in  1  pulse: clear the sticky error flags.
- overrun  out  1  sticky: line_start arrived while busy.
- drop_err  out  1  sticky: an ack arrived while fifo_full.

## Operation
- States:
  - S_IDLE → S_BUS on line_start when words_per_line≠0.
  - S_BUS → S_ACK_WAIT once words_per_line requests have issued.
  - S_ACK_WAIT → S_IDLE once all acks have been received.
- A request issues on a cycle with stb=1 and stall=0. After an issue, idx increments.
- stb is asserted in S_BUS only when outstanding<MAX_OUT and fifo_afull=0.
- cyc is high in S_BUS and S_ACK_WAIT.
- Bus request fields:
  - adr = row_adr + {idx,2'b00}, wrapping modulo 2^AWIDTH.
  - we=0, sel=4'hf, dat_o=0.
- Outstanding count: +1 on issue, −1 on ack; both in the same cycle leaves it unchanged. Acks are counted in both S_BUS and S_ACK_WAIT.
- FIFO write: fifo_write = ack & ~fifo_full. fifo_data is derived from dat_i.
- An ack while fifo_full is dropped and sets drop_err.
- End of line, at the S_ACK_WAIT→S_IDLE edge:
  - idx is cleared.
  - If rep_cnt==line_repeat: row_adr += stride and rep_cnt=0.
  - Otherwise: rep_cnt increments.
- frame_start:
  - Sets row_adr=base_adr and rep_cnt=0.
  - If it arrives while busy, the line in flight completes at its old addresses. The reload takes precedence over the end-of-line advance in the same cycle.
- line_start:
  - While busy: ignored, and overrun is set.
  - With words_per_line=0: ignored, no bus activity, no row advance.
- clr_err clears both sticky flags. A set condition in the same cycle wins.
- Configuration inputs are sampled at line_start. Changing them mid-line has no effect until the next line.

## Timing
- Reset values:
  - cyc=0, stb=0, adr=0, fifo_write=0, busy=0, overrun=0, drop_err=0.
  - Internal: row_adr=0, idx=0, rep_cnt=0, outstanding=0, state=S_IDLE.
- First request: line_start sampled at edge N gives cyc/stb high from cycle N+1.
- With no stall and no back-pressure, one issue per cycle, so the last request is at N+words_per_line.
- fifo_write and fifo_data are combinational from ack/dat_i, with zero latency.
- busy is high from N+1 until the cycle after the final ack.
- Reset asserted mid-line: all outputs return to reset values immediately (asynchronous) and the line is abandoned. Late acks after reset release are ignored and not written.

## Configuration
- GM_LINE_FETCH_BSWAP_EN defined: fifo_data = {dat_i[7:0], dat_i[15:8], dat_i[23:16], dat_i[31:24]}, for little-endian framebuffers.
- GM_LINE_FETCH_BSWAP_EN undefined: fifo_data = dat_i unchanged.

## Test plan
- Single line, zero-wait slave:
  - Stimulus: base_adr=0x1000, words_per_line=80, line_repeat=0, frame_start then line_start.
  - Expect: 80 reads at 0x1000..0x113C on consecutive cycles, 80 fifo_writes in order, busy low afterwards, next line starts at 0x1000+stride.
- Line repeat:
  - Stimulus: line_repeat=1, stride=320, 4 line_starts.
  - Expect: row addresses 0, 0, 320, 320.
- Outstanding limit:
  - Stimulus: MAX_OUT=4, slave acks 10 cycles after each request.
  - Expect: never more than 4 issued-unacked; stb drops after the 4th issue until an ack returns.
- Back-pressure:
  - Stimulus: fifo_afull=1 mid-line for 20 cycles.
  - Expect: no issues during that window, fetch resumes afterwards, drop_err stays 0.
  - Stimulus: force fifo_full during an ack.
  - Expect: drop_err=1 until clr_err.
- Boundaries:
  - line_start while busy: overrun=1, address sequence unaffected.
  - words_per_line=0: no cyc.
  - frame_start during S_ACK_WAIT: next line starts at base_adr.
  - Async reset mid-line: cyc=0 immediately.
- Byte-swap build:
  - Stimulus: dat_i=0x11223344.
  - Expect: fifo_data=0x44332211 with GM_LINE_FETCH_BSWAP_EN defined, 0x11223344 without.
